// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: shares the boot ROM between fetch and data ports, one transaction at a time.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed fetch priority.
module rom_bus_arbiter #(
    parameter logic [31:0] ROM_BASE     = 32'h0800_0000,
    parameter logic [31:0] ROM_SIZE     = 32'h0010_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        rom_write_enable,
    output logic [31:0] rom_address,
    output logic [31:0] rom_data_in,
    input  logic [31:0] rom_data_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [32:0] WIN_LO   = {1'b0, ROM_BASE};
    localparam logic [32:0] WIN_HI   = {1'b0, ROM_BASE} + {1'b0, ROM_SIZE};
    localparam logic [2:0]  LAST_CNT = 3'(READ_LATENCY);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_sel_d;
    logic        r_we;
    logic        r_err;
    logic        w_pick_d;
    logic        w_we;
    logic        w_hit;
    logic [31:0] w_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    assign w_pick_d = d_req && (!f_req || !r_last_d);
`else
    assign w_pick_d = d_req && !f_req;
`endif
    assign w_addr = w_pick_d ? d_addr : f_addr;
    assign w_we   = w_pick_d && d_we;
    assign w_hit  = ({1'b0, w_addr} >= WIN_LO) && ({1'b0, w_addr} < WIN_HI);

    // A miss enters ACCESS at its terminal count so it responds one cycle after the ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_cnt            <= 3'd0;
            r_sel_d          <= 1'b0;
            r_we             <= 1'b0;
            r_err            <= 1'b0;
            f_ack            <= 1'b0;
            f_rvalid         <= 1'b0;
            f_rdata          <= 32'h0;
            f_err            <= 1'b0;
            d_ack            <= 1'b0;
            d_rvalid         <= 1'b0;
            d_rdata          <= 32'h0;
            d_err            <= 1'b0;
            rom_write_enable <= 1'b0;
            rom_address      <= 32'h0;
            rom_data_in      <= 32'h0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            r_last_d         <= 1'b1;
`endif
        end else begin
            f_ack            <= 1'b0;
            d_ack            <= 1'b0;
            f_rvalid         <= 1'b0;
            d_rvalid         <= 1'b0;
            rom_write_enable <= 1'b0;
            case (r_state)
                IDLE: if (f_req || d_req) begin
                    r_sel_d <= w_pick_d;
                    r_we    <= w_we;
                    r_err   <= !w_hit;
                    f_ack   <= !w_pick_d;
                    d_ack   <= w_pick_d;
                    r_cnt   <= w_hit ? 3'd0 : LAST_CNT;
                    r_state <= ACCESS;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                    r_last_d <= w_pick_d;
`endif
                    if (w_hit) begin
                        rom_address      <= w_addr;
                        rom_data_in      <= w_pick_d ? d_wdata : 32'h0;
                        rom_write_enable <= w_we;
                    end
                end
                ACCESS: if (r_cnt == LAST_CNT) begin
                    r_state <= RESP;
                    if (r_sel_d) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= (r_we || r_err) ? 32'h0 : rom_data_out;
                        d_err    <= r_err;
                    end else begin
                        f_rvalid <= 1'b1;
                        f_rdata  <= r_err ? 32'h0 : rom_data_out;
                        f_err    <= r_err;
                    end
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb_rom_bus_arbiter: randomized bench with a timeline reference model and a behavioural ROM.
module tb_rom_bus_arbiter;
    parameter int RL = 1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] f_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        f_ack, f_rvalid, f_err, d_ack, d_rvalid, d_err, rom_write_enable;
    logic [31:0] f_rdata, d_rdata, rom_address, rom_data_in, rom_data_out;

    rom_bus_arbiter #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_write_enable(rom_write_enable), .rom_address(rom_address),
        .rom_data_in(rom_data_in), .rom_data_out(rom_data_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Behavioural ROM: synchronous, data valid RL cycles after the address is presented.
    logic [31:0] rom_mem [logic [31:0]];
    logic [31:0] pipe [RL];
    logic [31:0] rom_rv;
    always @(posedge clock) begin
        rom_rv = rom_mem.exists(rom_address) ? rom_mem[rom_address] : init_val(rom_address);
        if (rom_write_enable) rom_mem[rom_address] = rom_data_in;
        pipe[0] <= rom_rv;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data_out = pipe[RL-1];

    // Reference model: a timeline of expected events per cycle number.
    int cyc = 0;
    int free_at = 0;
    bit last_d = 1'b1;
    bit exp_fack [int], exp_dack [int], exp_frv [int], exp_drv [int], exp_we [int];
    bit exp_ferr [int], exp_derr [int];
    logic [31:0] exp_frd [int], exp_drd [int], exp_addr [int], exp_din [int];
    logic [31:0] exp_mem [logic [31:0]];
    bit m_pd, m_we, m_hit;
    logic [31:0] m_a, m_rd;
    int m_rv;

    always @(posedge clock) begin
        if (!reset_n) begin
            exp_fack.delete(); exp_dack.delete(); exp_frv.delete(); exp_drv.delete(); exp_we.delete();
            exp_ferr.delete(); exp_derr.delete(); exp_frd.delete(); exp_drd.delete();
            exp_addr.delete(); exp_din.delete();
            free_at = cyc + 1;
            last_d = 1'b1;
        end else if (cyc >= free_at && (f_req || d_req)) begin
            m_pd = d_req && (!f_req || (RR && !last_d));
            last_d = m_pd;
            m_a = m_pd ? d_addr : f_addr;
            m_we = m_pd && d_we;
            m_hit = (m_a >= 32'h0800_0000) && (m_a <= 32'h080F_FFFF);
            m_rv = m_hit ? cyc + 2 + RL : cyc + 2;
            if (m_hit) exp_addr[cyc+1] = m_a;
            if (m_hit && m_we) begin
                exp_we[cyc+1] = 1'b1;
                exp_din[cyc+1] = d_wdata;
                exp_mem[m_a] = d_wdata;
            end
            m_rd = (!m_hit || m_we) ? 32'h0 : (exp_mem.exists(m_a) ? exp_mem[m_a] : init_val(m_a));
            if (m_pd) begin
                exp_dack[cyc+1] = 1'b1; exp_drv[m_rv] = 1'b1; exp_drd[m_rv] = m_rd; exp_derr[m_rv] = !m_hit;
            end else begin
                exp_fack[cyc+1] = 1'b1; exp_frv[m_rv] = 1'b1; exp_frd[m_rv] = m_rd; exp_ferr[m_rv] = !m_hit;
            end
            free_at = m_rv + 1;
        end
        cyc++;
    end

    logic [31:0] f_hold = 32'h0, d_hold = 32'h0;
    logic any_out;
    assign any_out = f_ack | d_ack | f_rvalid | d_rvalid | rom_write_enable | f_err | d_err |
                     (|f_rdata) | (|d_rdata) | (|rom_address) | (|rom_data_in);

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("reset_outputs_zero", 32'(any_out), 32'd0);
            f_hold = 32'h0;
            d_hold = 32'h0;
        end else begin
            chk("f_ack", 32'(f_ack), 32'(exp_fack.exists(cyc)));
            chk("d_ack", 32'(d_ack), 32'(exp_dack.exists(cyc)));
            chk("f_rvalid", 32'(f_rvalid), 32'(exp_frv.exists(cyc)));
            chk("d_rvalid", 32'(d_rvalid), 32'(exp_drv.exists(cyc)));
            chk("rom_we", 32'(rom_write_enable), 32'(exp_we.exists(cyc)));
            if (exp_frv.exists(cyc)) begin
                f_hold = exp_frd[cyc];
                chk("f_err", 32'(f_err), 32'(exp_ferr[cyc]));
            end
            if (exp_drv.exists(cyc)) begin
                d_hold = exp_drd[cyc];
                chk("d_err", 32'(d_err), 32'(exp_derr[cyc]));
            end
            chk("f_rdata", f_rdata, f_hold);
            chk("d_rdata", d_rdata, d_hold);
            if (exp_addr.exists(cyc)) chk("rom_address", rom_address, exp_addr[cyc]);
            if (exp_din.exists(cyc)) chk("rom_data_in", rom_data_in, exp_din[cyc]);
        end
    end

    int f_lat, d_lat, f_ackc, d_ackc, we_cnt;
    logic [31:0] f_rd, d_rd;
    logic f_e, d_e;

    task automatic issue(input bit fr, input bit dr, input bit dwe,
                         input logic [31:0] fa, input logic [31:0] da, input logic [31:0] dw);
        int t0;
        bit fdone, ddone;
        @(posedge clock); #1;
        f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        t0 = cyc; fdone = !fr; ddone = !dr;
        f_lat = -1; d_lat = -1; f_ackc = -1; d_ackc = -1; we_cnt = 0;
        for (int i = 0; i < 60 && !(fdone && ddone); i++) begin
            @(negedge clock);
            if (rom_write_enable) we_cnt++;
            if (f_ack) begin f_ackc = cyc - t0; f_req = 1'b0; f_addr = $urandom; end
            if (d_ack) begin
                d_ackc = cyc - t0; d_req = 1'b0;
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
            end
            if (f_rvalid && !fdone) begin fdone = 1'b1; f_lat = cyc - t0; f_rd = f_rdata; f_e = f_err; end
            if (d_rvalid && !ddone) begin ddone = 1'b1; d_lat = cyc - t0; d_rd = d_rdata; d_e = d_err; end
        end
        chk("responses_done", 32'({fdone, ddone}), 32'd3);
        f_req = 1'b0; d_req = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom % 8)
            0: return 32'h0800_0000;
            1: return 32'h080F_FFFF;
            2: return 32'h0810_0000;
            3: return 32'h07FF_FFFF;
            4: return 32'hFFFF_FFFF;
            5: return 32'h080F_FFFC;
            default: return 32'h0800_0000 + 32'(($urandom % 16) * 4);
        endcase
    endfunction

    int g [3];
    int ng, rv_cnt;
    bit fdrop, ddrop, rfr, rdr;
    logic [31:0] exp_g;

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        issue(0, 1, 1, 32'h0, 32'h0800_0000, 32'h0123_4567);
        chk("wr_hit_ack_cycle", 32'(d_ackc), 32'd1);
        chk("wr_hit_we_cycles", 32'(we_cnt), 32'd1);
        chk("wr_hit_latency", 32'(d_lat), 32'(2 + RL));
        chk("wr_hit_rdata", d_rd, 32'h0);
        chk("wr_hit_err", 32'(d_e), 32'd0);

        issue(0, 1, 0, 32'h0, 32'h0800_0000, 32'h0);
        chk("rd_hit_latency", 32'(d_lat), 32'(2 + RL));
        chk("rd_hit_rdata", d_rd, 32'h0123_4567);
        chk("rd_hit_err", 32'(d_e), 32'd0);

        issue(0, 1, 1, 32'h0, 32'h0810_0000, 32'hFEDC_BA90);
        chk("wr_miss_we_cycles", 32'(we_cnt), 32'd0);
        chk("wr_miss_latency", 32'(d_lat), 32'd2);
        chk("wr_miss_err", 32'(d_e), 32'd1);
        issue(0, 1, 0, 32'h0, 32'h0810_0000, 32'h0);
        chk("rd_miss_latency", 32'(d_lat), 32'd2);
        chk("rd_miss_err", 32'(d_e), 32'd1);
        chk("rd_miss_rdata", d_rd, 32'h0);

        issue(0, 1, 1, 32'h0, 32'h080F_FFFF, 32'h89AB_CDEF);
        issue(1, 0, 0, 32'h080F_FFFF, 32'h0, 32'h0);
        chk("f_top_rdata", f_rd, 32'h89AB_CDEF);
        chk("f_top_err", 32'(f_e), 32'd0);
        chk("f_top_latency", 32'(f_lat), 32'(2 + RL));
        issue(1, 0, 0, 32'h07FF_FFFF, 32'h0, 32'h0);
        chk("f_below_err", 32'(f_e), 32'd1);
        chk("f_below_latency", 32'(f_lat), 32'd2);

        // Reset while a read is in ACCESS.
        @(posedge clock); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0800_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (d_ack) break;
        end
        d_req = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async_reset_zero", 32'(any_out), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rv_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (f_rvalid || d_rvalid) rv_cnt++;
        end
        chk("no_resp_after_reset", 32'(rv_cnt), 32'd0);

        // Contention: each requester re-raises in the cycle after its ack.
        @(posedge clock); #1;
        f_addr = 32'h0800_0000; d_addr = 32'h0800_0004; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1; ng = 0; fdrop = 1'b0; ddrop = 1'b0;
        for (int i = 0; i < 200 && ng < 3; i++) begin
            @(negedge clock);
            if (f_ack) begin g[ng] = 0; ng++; f_req = 1'b0; fdrop = 1'b1; end
            else if (fdrop) begin f_req = 1'b1; fdrop = 1'b0; end
            if (d_ack) begin g[ng] = 1; ng++; d_req = 1'b0; ddrop = 1'b1; end
            else if (ddrop) begin d_req = 1'b1; ddrop = 1'b0; end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (f_ack) f_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("grant_count", 32'(ng), 32'd3);
        exp_g = RR ? 32'b010 : 32'b000;
        for (int i = 0; i < 3; i++) chk($sformatf("grant_%0d", i), 32'(g[i]), 32'(exp_g[2-i]));

        issue(1, 0, 0, 32'h0800_0000, 32'h0, 32'h0);
        chk("f_after_reset_rdata", f_rd, 32'h0123_4567);
        chk("f_after_reset_err", 32'(f_e), 32'd0);
        chk("f_after_reset_latency", 32'(f_lat), 32'(2 + RL));

        for (int i = 0; i < 60; i++) begin
            rfr = 1'($urandom);
            rdr = rfr ? 1'($urandom) : 1'b1;
            issue(rfr, rdr, 1'($urandom), rnd_addr(), rnd_addr(), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
